// File: rtl/loader_pkg.sv
// Shared definitions for the tile-mesh loader: FSM state encoding, ACTIVE
// window length and a width helper for index fields.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int ACTIVE_CYCLES = 2;

    // Index width for n items; never below 1 so ports stay legal.
    function automatic int tile_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps,
// returning the first set request as one-hot and as an index.
module rr_arbiter
    import loader_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = tile_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/loader_arbiter.sv
// Round-robin loader for the tile mesh: one granted load runs a fixed
// SETUP / ACTIVE x2 / RELEASE window; all outputs are registered.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | wait for any REQ; grant and latch winner's address/data
//  ST_SETUP   | present tile-local address and data, no select
//  ST_ACTIVE  | assert one-hot tile select and write (skipped if out of range)
//  ST_RELEASE | drop select, pulse ACK (and ERR_ADDR), advance rr pointer
module loader_arbiter
    import loader_pkg::*;
#(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 8,
    parameter int NB_TILES     = 4,
    parameter int NB_REQ       = 3
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic [NB_REQ-1:0]                         REQ,
    input  logic [NB_REQ*ADDRESS_SIZE-1:0]            REQ_ADDRESS,
    input  logic [NB_REQ*DATA_SIZE-1:0]               REQ_DATA,
    output logic [NB_REQ-1:0]                         ACK,
    output logic                                      ERR_ADDR,
    output logic                                      BUSY,
    output logic [NB_TILES-1:0]                       SELECT_TILE,
    output logic [ADDRESS_SIZE-tile_bits(NB_TILES)-1:0] ADDRESS_TILE,
    output logic [DATA_SIZE-1:0]                      DATA_TILE,
    output logic                                      WRITE_TILE
);

    localparam int TILE_BITS  = tile_bits(NB_TILES);
    localparam int LOCAL_BITS = ADDRESS_SIZE - TILE_BITS;
    localparam int REQ_BITS   = tile_bits(NB_REQ);
    localparam logic [TILE_BITS:0] TILE_LIMIT = (TILE_BITS+1)'(NB_TILES);

    state_t                  state, state_nxt;
    logic [1:0]              phase_cnt;
    logic [REQ_BITS-1:0]     ptr;
    logic [REQ_BITS-1:0]     grant_idx_q;
    logic [NB_REQ-1:0]       grant_oh_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0]    data_q;

    logic [NB_REQ-1:0]       arb_grant;
    logic [REQ_BITS-1:0]     arb_idx;
    logic                    take_grant;

    logic [TILE_BITS-1:0]    tile_idx;
    logic                    in_range;
    logic [NB_TILES-1:0]     tile_oh;

    logic [NB_TILES-1:0]     sel_d;
    logic [NB_REQ-1:0]       ack_d;
    logic                    write_d, err_d, busy_d, load_d;

    rr_arbiter #(.N(NB_REQ), .IW(REQ_BITS)) u_rr (
        .req       (REQ),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign take_grant = (state == ST_IDLE) && (|REQ);
    assign tile_idx   = addr_q[ADDRESS_SIZE-1 -: TILE_BITS];
    assign in_range   = {1'b0, tile_idx} < TILE_LIMIT;
    assign tile_oh    = {{(NB_TILES-1){1'b0}}, 1'b1} << tile_idx;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (|REQ) state_nxt = ST_SETUP;
            ST_SETUP:   state_nxt = ST_ACTIVE;
            ST_ACTIVE:  if (phase_cnt == 2'd0) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Decoded per state, then registered one cycle later below.
    always_comb begin
        sel_d   = '0;
        write_d = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        load_d  = 1'b0;
        busy_d  = (state != ST_IDLE);
        case (state)
            ST_SETUP:   load_d = 1'b1;
            ST_ACTIVE: begin
                sel_d   = in_range ? tile_oh : '0;
                write_d = in_range;
            end
            ST_RELEASE: begin
                ack_d = grant_oh_q;
                err_d = !in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_cnt   <= '0;
            ptr         <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            if (take_grant) begin
                grant_idx_q <= arb_idx;
                grant_oh_q  <= arb_grant;
                addr_q      <= REQ_ADDRESS[arb_idx*ADDRESS_SIZE +: ADDRESS_SIZE];
                data_q      <= REQ_DATA[arb_idx*DATA_SIZE +: DATA_SIZE];
            end
            if (state == ST_SETUP)
                phase_cnt <= 2'(ACTIVE_CYCLES - 1);
            else if (state == ST_ACTIVE && phase_cnt != 2'd0)
                phase_cnt <= phase_cnt - 2'd1;
            if (state == ST_RELEASE)
                ptr <= grant_idx_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ACK          <= '0;
            ERR_ADDR     <= 1'b0;
            BUSY         <= 1'b0;
            SELECT_TILE  <= '0;
            WRITE_TILE   <= 1'b0;
            ADDRESS_TILE <= '0;
            DATA_TILE    <= '0;
        end else begin
            ACK         <= ack_d;
            ERR_ADDR    <= err_d;
            BUSY        <= busy_d;
            SELECT_TILE <= sel_d;
            WRITE_TILE  <= write_d;
            if (load_d) begin
                ADDRESS_TILE <= addr_q[LOCAL_BITS-1:0];
                DATA_TILE    <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_loader_arbiter.sv
// Directed bench for loader_arbiter: a 4-tile instance for the main flows
// and a 3-tile instance for out-of-range tile indices.
module tb_loader_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;

    logic [2:0]  REQ;
    logic [29:0] REQ_ADDRESS;
    logic [23:0] REQ_DATA;
    logic [2:0]  ACK;
    logic        ERR_ADDR, BUSY, WRITE_TILE;
    logic [3:0]  SELECT_TILE;
    logic [7:0]  ADDRESS_TILE, DATA_TILE;

    logic [2:0]  req3;
    logic [29:0] req_address3;
    logic [23:0] req_data3;
    logic [2:0]  ack3;
    logic        err3, busy3, write3;
    logic [2:0]  select3;
    logic [7:0]  address3, data3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    loader_arbiter #(.ADDRESS_SIZE(10), .DATA_SIZE(8), .NB_TILES(4), .NB_REQ(3)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_ADDRESS(REQ_ADDRESS),
        .REQ_DATA(REQ_DATA), .ACK(ACK), .ERR_ADDR(ERR_ADDR), .BUSY(BUSY),
        .SELECT_TILE(SELECT_TILE), .ADDRESS_TILE(ADDRESS_TILE),
        .DATA_TILE(DATA_TILE), .WRITE_TILE(WRITE_TILE)
    );

    loader_arbiter #(.ADDRESS_SIZE(10), .DATA_SIZE(8), .NB_TILES(3), .NB_REQ(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .REQ(req3), .REQ_ADDRESS(req_address3),
        .REQ_DATA(req_data3), .ACK(ack3), .ERR_ADDR(err3), .BUSY(busy3),
        .SELECT_TILE(select3), .ADDRESS_TILE(address3),
        .DATA_TILE(data3), .WRITE_TILE(write3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for ACK on the main instance, counting falling edges.
    task automatic wait_ack(output logic [2:0] ack_seen, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (ACK == 3'b000 && cyc < 20);
        ack_seen = ACK;
    endtask

    logic [2:0] ack_v;
    int         cyc_v;
    logic [2:0] exp_contention [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] exp_fair       [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        REQ = '0; REQ_ADDRESS = '0; REQ_DATA = '0;
        req3 = '0; req_address3 = '0; req_data3 = '0;
        repeat (3) @(negedge CLK);
        check("rst_sel",  SELECT_TILE, 0);
        check("rst_ack",  ACK, 0);
        check("rst_busy", BUSY, 0);
        check("rst_addr", ADDRESS_TILE, 0);
        check("rst_data", DATA_TILE, 0);
        check("rst_wr",   WRITE_TILE, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Single load, full phase walk
        REQ = 3'b001;
        REQ_ADDRESS[0 +: 10] = 10'b11_0000_0101;
        REQ_DATA[0 +: 8] = 8'hA5;
        @(negedge CLK);
        check("t1_c1_sel", SELECT_TILE, 0);
        @(negedge CLK);
        check("t1_c2_addr", ADDRESS_TILE, 8'h05);
        check("t1_c2_data", DATA_TILE, 8'hA5);
        check("t1_c2_sel",  SELECT_TILE, 0);
        check("t1_c2_wr",   WRITE_TILE, 0);
        check("t1_c2_busy", BUSY, 1);
        @(negedge CLK);
        check("t1_c3_sel", SELECT_TILE, 4'b1000);
        check("t1_c3_wr",  WRITE_TILE, 1);
        check("t1_c3_ack", ACK, 0);
        @(negedge CLK);
        check("t1_c4_sel", SELECT_TILE, 4'b1000);
        check("t1_c4_ack", ACK, 0);
        @(negedge CLK);
        check("t1_c5_ack", ACK, 3'b001);
        check("t1_c5_err", ERR_ADDR, 0);
        check("t1_c5_sel", SELECT_TILE, 0);
        check("t1_c5_wr",  WRITE_TILE, 0);
        REQ = '0;
        @(negedge CLK);
        check("t1_c6_ack",  ACK, 0);
        check("t1_c6_hold", ADDRESS_TILE, 8'h05);

        // Input change after grant: latched address must win
        REQ = 3'b100;
        REQ_ADDRESS[20 +: 10] = 10'b01_0011_1100;
        REQ_DATA[16 +: 8] = 8'h5A;
        @(negedge CLK);
        REQ_ADDRESS[20 +: 10] = 10'b10_1111_1111;
        REQ_DATA[16 +: 8] = 8'hFF;
        @(negedge CLK);
        check("t6_addr", ADDRESS_TILE, 8'h3C);
        check("t6_data", DATA_TILE, 8'h5A);
        @(negedge CLK);
        check("t6_sel", SELECT_TILE, 4'b0010);
        @(negedge CLK);
        @(negedge CLK);
        check("t6_ack", ACK, 3'b100);
        REQ = '0;
        @(negedge CLK);

        // Contention from pointer=2: order 0,1,2, five cycles apart
        REQ = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_ack(ack_v, cyc_v);
            check($sformatf("t2_ack%0d", i), ack_v, exp_contention[i]);
            check($sformatf("t2_lat%0d", i), cyc_v, 5);
            REQ = REQ & ~ack_v;
        end
        @(negedge CLK);

        // Fairness: requester 0 re-asserts, requester 2 held
        REQ = 3'b101;
        for (int i = 0; i < 4; i++) begin
            wait_ack(ack_v, cyc_v);
            check($sformatf("t3_ack%0d", i), ack_v, exp_fair[i]);
            check($sformatf("t3_lat%0d", i), cyc_v, 5);
            REQ[0] = (ack_v == 3'b100);
        end
        REQ = '0;
        @(negedge CLK);

        // Reset mid-ACTIVE, pointer back to 0
        REQ = 3'b001;
        REQ_ADDRESS[0 +: 10] = 10'b00_0000_0111;
        repeat (3) @(negedge CLK);
        check("t5_pre_sel", SELECT_TILE, 4'b0001);
        #1 RESET = 1'b1;
        REQ = '0;
        #1;
        check("t5_sel",  SELECT_TILE, 0);
        check("t5_wr",   WRITE_TILE, 0);
        check("t5_busy", BUSY, 0);
        check("t5_addr", ADDRESS_TILE, 0);
        check("t5_data", DATA_TILE, 0);
        check("t5_ack",  ACK, 0);
        repeat (2) @(negedge CLK);
        check("t5_noack", ACK, 0);
        RESET = 1'b0;
        @(negedge CLK);
        REQ = 3'b011;
        REQ_ADDRESS[10 +: 10] = 10'b01_0000_0001;
        wait_ack(ack_v, cyc_v);
        check("t5_post_ack", ack_v, 3'b010);
        check("t5_post_lat", cyc_v, 5);
        REQ = '0;
        @(negedge CLK);

        // Out-of-range tile on the 3-tile instance
        req3 = 3'b001;
        req_address3[0 +: 10] = 10'b11_0000_0001;
        req_data3[0 +: 8] = 8'h11;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            check($sformatf("t4_sel_c%0d", c), select3, 0);
            check($sformatf("t4_wr_c%0d", c), write3, 0);
            if (c == 4) begin
                check("t4_ack_c4", ack3, 0);
                check("t4_err_c4", err3, 0);
            end
        end
        check("t4_ack", ack3, 3'b001);
        check("t4_err", err3, 1);
        req3 = '0;
        @(negedge CLK);
        check("t4_err_after", err3, 0);
        check("t4_ack_after", ack3, 0);

        // In-range tile 2 on the same instance
        req3 = 3'b001;
        req_address3[0 +: 10] = 10'b10_0000_0010;
        repeat (3) @(negedge CLK);
        check("t4b_sel", select3, 3'b100);
        check("t4b_wr",  write3, 1);
        repeat (2) @(negedge CLK);
        check("t4b_ack", ack3, 3'b001);
        check("t4b_err", err3, 0);
        req3 = '0;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
